// File: rtl/ch_fifo_drain.sv
// Read-side drain engine: alternates bursts from two capture FIFOs (optionally
// headed by a sequence word) into the Xillybus upstream FIFO through a 2-entry queue.
module ch_fifo_drain #(
  parameter int unsigned BURST_LEN = 64,
  parameter bit          HDR_EN    = 1'b1
) (
  input  logic        rd_clk,
  input  logic        rst,
  input  logic        open,
  input  logic [31:0] ch1_dout,
  input  logic        ch1_empty,
  output logic        ch1_rd_en,
  input  logic [31:0] ch2_dout,
  input  logic        ch2_empty,
  output logic        ch2_rd_en,
  input  logic        xb_full,
  output logic [31:0] xb_din,
  output logic        xb_wr_en,
  output logic        busy
);

  localparam logic [15:0] BURST_W = 16'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_e;

  localparam state_e RUN_STATE = HDR_EN ? HDR : DATA;

  state_e      state_q, state_d;
  logic        cur_ch_q, cur_ch_d;   // 0 = ch1, 1 = ch2
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [15:0] seq_q, seq_d;
  logic [31:0] slot0_q, slot0_d;
  logic [31:0] slot1_q, slot1_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        inflight_q, inflight_d;

  logic        pop;
  logic        credit;
  logic        hdr_push;
  logic        push;
  logic        rd_issue;
  logic        burst_done;
  logic [1:0]  occ_post;
  logic [31:0] push_word;

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_ch_q   <= 1'b0;
      word_cnt_q <= '0;
      seq_q      <= '0;
      slot0_q    <= '0;
      slot1_q    <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_ch_q   <= cur_ch_d;
      word_cnt_q <= word_cnt_d;
      seq_q      <= seq_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
    end
  end

  // Queue bookkeeping. Credit counts the slot a returning read will take this
  // cycle, so a new read is only issued when the post-pop queue plus the
  // returning word still leaves room for it.
  always_comb begin
    pop       = (cnt_q != 2'd0) && !xb_full;
    occ_post  = cnt_q - {1'b0, pop} + {1'b0, inflight_q};
    credit    = (occ_post < 2'd2);
    hdr_push  = (state_q == HDR) && credit;
    push      = inflight_q | hdr_push;
    push_word = inflight_q ? (cur_ch_q ? ch2_dout : ch1_dout)
                           : {8'hA5, 7'b0, cur_ch_q, seq_q};
    slot0_d   = slot0_q;
    slot1_d   = slot1_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push) begin
      if (wr_ptr_q) slot1_d = push_word;
      else          slot0_d = push_word;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_comb begin
    state_d    = state_q;
    cur_ch_d   = cur_ch_q;
    word_cnt_d = word_cnt_q;
    seq_d      = seq_q;
    inflight_d = rd_issue;
    burst_done = (word_cnt_q == BURST_W) && !inflight_q;
    case (state_q)
      IDLE: begin
        if (open) begin
          state_d    = RUN_STATE;
          cur_ch_d   = 1'b0;
          word_cnt_d = '0;
        end else begin
          seq_d = '0;
        end
      end
      HDR: begin
        if (hdr_push) state_d = DATA;
      end
      DATA: begin
        if (rd_issue) word_cnt_d = word_cnt_q + 16'd1;
        if (burst_done) begin
          cur_ch_d   = ~cur_ch_q;
          word_cnt_d = '0;
          if (cur_ch_q) seq_d = seq_q + 16'd1;
          state_d = open ? RUN_STATE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    logic rd_ok;
    rd_ok     = (state_q == DATA) && credit && (word_cnt_q < BURST_W);
    ch1_rd_en = rd_ok && !cur_ch_q && !ch1_empty;
    ch2_rd_en = rd_ok &&  cur_ch_q && !ch2_empty;
    rd_issue  = ch1_rd_en | ch2_rd_en;
    xb_wr_en  = (cnt_q != 2'd0) && !xb_full;
    xb_din    = rd_ptr_q ? slot1_q : slot0_q;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_ch_fifo_drain.sv
// Bench for ch_fifo_drain: queue-based FIFO sources and a stream-order reference
// model (header/burst/sequence rules) for a headed BURST_LEN=4 instance and a headerless BURST_LEN=1 instance.
module tb_ch_fifo_drain;

  localparam int unsigned BL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, open, xb_full;
  logic        ch1_empty = 1'b1, ch2_empty = 1'b1;
  logic [31:0] ch1_dout = '0, ch2_dout = '0;
  logic        ch1_rd_en, ch2_rd_en, xb_wr_en, busy;
  logic [31:0] xb_din;

  logic        b_rst, b_open, b_xb_full;
  logic [31:0] b_ch1_dout = '0, b_ch2_dout = '0;
  logic        b_ch1_rd_en, b_ch2_rd_en, b_xb_wr_en, b_busy;
  logic [31:0] b_xb_din;

  ch_fifo_drain #(.BURST_LEN(BL), .HDR_EN(1'b1)) dut_a (
    .rd_clk(clk), .rst(rst), .open(open),
    .ch1_dout(ch1_dout), .ch1_empty(ch1_empty), .ch1_rd_en(ch1_rd_en),
    .ch2_dout(ch2_dout), .ch2_empty(ch2_empty), .ch2_rd_en(ch2_rd_en),
    .xb_full(xb_full), .xb_din(xb_din), .xb_wr_en(xb_wr_en), .busy(busy)
  );

  ch_fifo_drain #(.BURST_LEN(1), .HDR_EN(1'b0)) dut_b (
    .rd_clk(clk), .rst(b_rst), .open(b_open),
    .ch1_dout(b_ch1_dout), .ch1_empty(1'b0), .ch1_rd_en(b_ch1_rd_en),
    .ch2_dout(b_ch2_dout), .ch2_empty(1'b0), .ch2_rd_en(b_ch2_rd_en),
    .xb_full(b_xb_full), .xb_din(b_xb_din), .xb_wr_en(b_xb_wr_en), .busy(b_busy)
  );

  int unsigned n_chk = 0, n_err = 0;

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic want);
    n_chk++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, want);
    end
  endtask

  // Source FIFOs (standard read latency) and the host-side record of what was loaded
  logic [31:0] fifo1[$], fifo2[$], exp1[$], exp2[$];

  always @(posedge clk) begin
    if (ch1_rd_en && fifo1.size() != 0) ch1_dout <= fifo1.pop_front();
    if (ch2_rd_en && fifo2.size() != 0) ch2_dout <= fifo2.pop_front();
    ch1_empty <= (fifo1.size() == 0);
    ch2_empty <= (fifo2.size() == 0);
  end

  task automatic load1(input logic [31:0] base, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin fifo1.push_back(base + i); exp1.push_back(base + i); end
  endtask

  task automatic load2(input logic [31:0] base, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin fifo2.push_back(base + i); exp2.push_back(base + i); end
  endtask

  // Instance B sources: the n-th word read from chN is N*0x1000 + n
  int unsigned b_src1 = 0, b_src2 = 0;
  always @(posedge clk) begin
    if (b_ch1_rd_en) begin b_ch1_dout <= 32'h1000 + b_src1; b_src1++; end
    if (b_ch2_rd_en) begin b_ch2_dout <= 32'h2000 + b_src2; b_src2++; end
  end

  bit rand_full = 1'b0;
  initial begin
    xb_full = 1'b0;
    b_xb_full = 1'b0;
    forever begin
      @(posedge clk); #1;
      xb_full   = rand_full ? 1'($urandom_range(0, 1)) : 1'b0;
      b_xb_full = 1'($urandom_range(0, 1));
    end
  end

  // Reference stream model for instance A
  int unsigned m_pos = 0;
  bit          m_ch  = 1'b0;
  logic [15:0] m_seq = '0;
  int unsigned n_wr = 0, n_dwr = 0, n_rd = 0, cyc = 0, last_wr = 0;
  bit          chk_rate = 1'b0;

  always @(negedge clk) begin
    logic [31:0] want;
    cyc++;
    if (xb_full) chk1("wr_while_full", xb_wr_en, 1'b0);
    if (ch1_rd_en || ch2_rd_en) begin
      chk1("rd_exclusive", ch1_rd_en & ch2_rd_en, 1'b0);
      n_rd++;
    end
    if (ch1_rd_en) chk1("rd1_nonempty", ch1_empty, 1'b0);
    if (ch2_rd_en) chk1("rd2_nonempty", ch2_empty, 1'b0);
    if (xb_wr_en) begin
      n_wr++;
      if (m_pos == 0) begin
        want = {8'hA5, 7'b0, m_ch, m_seq};
      end else begin
        if (m_ch) want = (exp2.size() != 0) ? exp2.pop_front() : 32'hDEAD_BEEF;
        else      want = (exp1.size() != 0) ? exp1.pop_front() : 32'hDEAD_BEEF;
        if (chk_rate && m_pos >= 2) chk32("rate", cyc - last_wr, 32'd1);
        n_dwr++;
      end
      chk32("xb_din", xb_din, want);
      last_wr = cyc;
      m_pos++;
      if (m_pos == BL + 1) begin
        m_pos = 0;
        if (m_ch) m_seq++;
        m_ch = ~m_ch;
      end
    end
    chk1("data_in_flight_le2", 1'(n_rd <= n_dwr + 2), 1'b1);
  end

  // Reference model for instance B: strict ch1/ch2 alternation, no headers
  bit          b_ch = 1'b0;
  int unsigned b_k1 = 0, b_k2 = 0, b_n = 0;

  always @(negedge clk) begin
    logic [31:0] want;
    if (b_xb_full) chk1("b_wr_while_full", b_xb_wr_en, 1'b0);
    if (b_ch1_rd_en || b_ch2_rd_en) chk1("b_rd_exclusive", b_ch1_rd_en & b_ch2_rd_en, 1'b0);
    if (b_xb_wr_en) begin
      want = b_ch ? 32'h2000 + b_k2 : 32'h1000 + b_k1;
      chk32("b_xb_din", b_xb_din, want);
      if (b_ch) b_k2++; else b_k1++;
      b_ch = ~b_ch;
      b_n++;
    end
  end

  task automatic wait_wr(input int unsigned tgt, input int unsigned budget);
    int unsigned k = 0;
    while (n_wr < tgt && k < budget) begin @(negedge clk); k++; end
    chk1("wait_wr", 1'(n_wr >= tgt), 1'b1);
  endtask

  task automatic wait_pos(input bit ch, input int unsigned pos, input int unsigned budget);
    int unsigned k = 0;
    while (!(m_ch == ch && m_pos == pos) && k < budget) begin @(negedge clk); k++; end
    chk1("wait_pos", 1'(m_ch == ch && m_pos == pos), 1'b1);
  endtask

  task automatic chk_quiet(input string tag);
    chk1({tag, "_ch1_rd_en"}, ch1_rd_en, 1'b0);
    chk1({tag, "_ch2_rd_en"}, ch2_rd_en, 1'b0);
    chk1({tag, "_xb_wr_en"},  xb_wr_en,  1'b0);
    chk32({tag, "_xb_din"},   xb_din,    32'h0);
    chk1({tag, "_busy"},      busy,      1'b0);
  endtask

  initial begin
    int unsigned base;
    rst = 1'b1; b_rst = 1'b1; open = 1'b0; b_open = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b0; b_rst = 1'b0; b_open = 1'b1;

    // Unthrottled stream: header + 4 words per burst, one data word per cycle
    load1(32'h100, 16);
    load2(32'h200, 16);
    open = 1'b1;
    chk_rate = 1'b1;
    wait_wr(20, 400);
    chk_rate = 1'b0;

    // Random back-pressure: same ordering, nothing lost or repeated
    rand_full = 1'b1;
    wait_wr(40, 2000);
    rand_full = 1'b0;

    // ch1 short of data: stall in ch1 burst while ch2 has words available
    wait_wr(41, 200);
    load1(32'h110, 2);
    load2(32'h210, 4);
    wait_wr(43, 200);
    repeat (10) begin
      @(negedge clk);
      chk1("stall_ch2_rd_en", ch2_rd_en, 1'b0);
      chk32("stall_n_wr", n_wr, 32'd43);
      chk1("stall_busy", busy, 1'b1);
    end
    load1(32'h112, 2);
    wait_wr(50, 200);

    // Close after the 2nd data word of a ch1 burst: burst completes, no ch2
    load1(32'h114, 4);
    load2(32'h214, 4);
    wait_pos(1'b0, 3, 200);
    open = 1'b0;
    wait_wr(55, 200);
    repeat (10) @(negedge clk);
    chk1("close_busy", busy, 1'b0);
    chk1("close_xb_wr_en", xb_wr_en, 1'b0);
    chk32("close_n_wr", n_wr, 32'd55);
    chk32("close_ch2_left", 32'(fifo2.size()), 32'd4);

    // Reopen: fresh session from ch1 with seq=0
    m_ch = 1'b0; m_pos = 0; m_seq = '0;
    load1(32'h118, 4);
    open = 1'b1;
    wait_wr(65, 200);

    // Reset pulse in the middle of a ch1 burst
    load1(32'h11C, 10);
    load2(32'h218, 4);
    wait_pos(1'b0, 2, 200);
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("midrst");
    rst = 1'b0;
    exp1 = fifo1;
    exp2 = fifo2;
    m_ch = 1'b0; m_pos = 0; m_seq = '0;
    n_rd = n_dwr;
    base = n_wr;
    wait_wr(base + 10, 300);

    open = 1'b0;
    b_open = 1'b0;
    repeat (20) @(negedge clk);
    chk1("b_progress", 1'(b_n >= 40), 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
